// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: EX-stage flags, shared CSR port and pipeline control seen by the trap sequencer
interface trap_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic        illegal_instr;
    logic        env_call;
    logic        break_point;
    logic        mret_instr;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    modport master (
        input  ex_valid, ex_pc, ex_instr, illegal_instr, env_call, break_point, mret_instr, csr_rdata,
        output csr_raddr, csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid, redirect_pc
    );
    modport slave (
        output ex_valid, ex_pc, ex_instr, illegal_instr, env_call, break_point, mret_instr, csr_rdata,
        input  csr_raddr, csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences M-mode trap entry / MRET over the shared CSR port, then one PC redirect
module trap_ctrl #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
    input logic clk,
    input logic rst_n,
    trap_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_TVEC, M_STATUS, M_EPC, REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [31:2] pc_q, pc_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:2] target_q, target_d;
    logic        trap, ret;
    logic [31:0] rd;

    assign rd   = bus.csr_rdata;
    // Gating with rst_n keeps every output at 0 while reset is held, even in IDLE.
    assign trap = rst_n & bus.ex_valid & (bus.illegal_instr | bus.env_call | bus.break_point);
    assign ret  = rst_n & bus.ex_valid & bus.mret_instr & ~trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        cause_d            = cause_q;
        tval_d             = tval_q;
        target_d           = target_q;
        bus.csr_raddr      = '0;
        bus.csr_we         = 1'b0;
        bus.csr_waddr      = '0;
        bus.csr_wdata      = '0;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (state_q)
            IDLE: if (trap | ret) begin
                bus.stall = 1'b1;
                bus.flush = 1'b1;
                pc_d      = bus.ex_pc[31:2];
                cause_d   = bus.illegal_instr ? 4'd2 : bus.env_call ? 4'd11 : 4'd3;
                tval_d    = bus.illegal_instr ? bus.ex_instr : bus.env_call ? 32'd0 : bus.ex_pc;
                state_d   = trap ? T_EPC : M_STATUS;
            end
            T_EPC: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MEPC_ADDR;
                bus.csr_wdata = {pc_q, 2'b00};
                state_d       = T_CAUSE;
            end
            T_CAUSE: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MCAUSE_ADDR;
                bus.csr_wdata = {28'd0, cause_q};
                state_d       = T_TVAL;
            end
            T_TVAL: begin
                bus.stall     = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MTVAL_ADDR;
                bus.csr_wdata = tval_q;
                state_d       = T_STATUS;
            end
            T_STATUS: begin
                bus.stall     = 1'b1;
                bus.csr_raddr = MSTATUS_ADDR;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MSTATUS_ADDR;
                bus.csr_wdata = {rd[31:13], 2'b11, rd[10:8], rd[3], rd[6:4], 1'b0, rd[2:0]};
                state_d       = T_TVEC;
            end
            T_TVEC: begin
                bus.stall     = 1'b1;
                bus.csr_raddr = MTVEC_ADDR;
                target_d      = rd[31:2];
                state_d       = REDIRECT;
            end
            M_STATUS: begin
                bus.stall     = 1'b1;
                bus.csr_raddr = MSTATUS_ADDR;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = MSTATUS_ADDR;
                bus.csr_wdata = {rd[31:13], 2'b11, rd[10:8], 1'b1, rd[6:4], rd[7], rd[2:0]};
                state_d       = M_EPC;
            end
            M_EPC: begin
                bus.stall     = 1'b1;
                bus.csr_raddr = MEPC_ADDR;
                target_d      = rd[31:2];
                state_d       = REDIRECT;
            end
            REDIRECT: begin
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = {target_q, 2'b00};
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed trap/MRET sequences checked by a cycle-stamped event scoreboard
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mstatus_m = 32'h8, mtvec_m = 32'h201, mepc_m = 32'h104;

    typedef struct {
        int          c;
        bit          rd;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t q[$];
    bit  exp_stall[int];
    bit  exp_flush[int];

    trap_ctrl_if bus();
    trap_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb bus.csr_rdata = bus.csr_raddr == 12'h300 ? mstatus_m :
                                bus.csr_raddr == 12'h305 ? mtvec_m :
                                bus.csr_raddr == 12'h341 ? mepc_m : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input bit r, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.c = c; e.rd = r; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic match(input bit r, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        if (q.size() == 0) begin
            chk(r ? "spurious_redirect" : "spurious_csr_we", r ? d : {20'd0, a}, 32'hDEAD_BEEF);
        end else begin
            e = q.pop_front();
            chk("event_cycle", cyc, e.c);
            chk("event_kind", {31'd0, r}, {31'd0, e.rd});
            if (!r) chk("csr_waddr", {20'd0, a}, {20'd0, e.addr});
            chk(r ? "redirect_pc" : "csr_wdata", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", {31'd0, bus.stall}, exp_stall.exists(cyc) ? 32'd1 : 32'd0);
        chk("flush", {31'd0, bus.flush}, exp_flush.exists(cyc) ? 32'd1 : 32'd0);
        while (q.size() > 0 && q[0].c < cyc) begin
            chk("missing_event", q[0].c, 32'hFFFF_FFFF);
            void'(q.pop_front());
        end
        if (bus.csr_we) match(1'b0, bus.csr_waddr, bus.csr_wdata);
        if (bus.redirect_valid) match(1'b1, 12'h0, bus.redirect_pc);
    end

    task automatic clear_in();
        bus.ex_valid = 0; bus.illegal_instr = 0; bus.env_call = 0;
        bus.break_point = 0; bus.mret_instr = 0;
    endtask

    task automatic seq(input bit ill, ec, eb, mr, input logic [31:0] pc, instr, input bit is_ret,
                       input logic [31:0] mepc_w, cause_w, tval_w, status_w, target);
        int base, lat;
        bus.ex_valid = 1; bus.illegal_instr = ill; bus.env_call = ec;
        bus.break_point = eb; bus.mret_instr = mr; bus.ex_pc = pc; bus.ex_instr = instr;
        base = cyc;
        lat  = is_ret ? 3 : 6;
        for (int i = 0; i < lat; i++) exp_stall[base + i] = 1;
        exp_flush[base] = 1;
        exp_flush[base + lat] = 1;
        if (is_ret) push(base + 1, 0, 12'h300, status_w);
        else begin
            push(base + 1, 0, 12'h341, mepc_w);
            push(base + 2, 0, 12'h342, cause_w);
            push(base + 3, 0, 12'h343, tval_w);
            push(base + 4, 0, 12'h300, status_w);
        end
        push(base + lat, 1, 12'h0, target);
        for (int i = 1; i <= lat + 1; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                bus.ex_valid = 1; bus.env_call = 1; bus.break_point = 1; bus.mret_instr = 1;
                bus.illegal_instr = 1; bus.ex_pc = 32'h0BAD_0000;
            end
            if (i == lat) clear_in();
        end
    endtask

    initial begin
        int base;
        clear_in();
        bus.ex_pc = 0; bus.ex_instr = 0;
        repeat (3) @(posedge clk);
        #1;
        bus.ex_valid = 1; bus.env_call = 1;
        #1;
        chk("rst_stall", {31'd0, bus.stall}, 0);
        chk("rst_csr_we", {31'd0, bus.csr_we}, 0);
        chk("rst_csr_raddr", {20'd0, bus.csr_raddr}, 0);
        chk("rst_redirect_pc", bus.redirect_pc, 0);
        clear_in();
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        seq(0, 1, 0, 0, 32'h100, 32'h73, 0, 32'h100, 32'd11, 32'h0, 32'h1880, 32'h200);
        repeat (2) @(posedge clk);
        #1;
        seq(1, 0, 0, 0, 32'h44, 32'hFFFF_FFFF, 0, 32'h44, 32'd2, 32'hFFFF_FFFF, 32'h1880, 32'h200);
        seq(0, 0, 1, 0, 32'h80, 32'h0010_0073, 0, 32'h80, 32'd3, 32'h80, 32'h1880, 32'h200);
        mstatus_m = 32'h1880;
        seq(0, 0, 0, 1, 32'h500, 32'h3020_0073, 1, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h104);
        mstatus_m = 32'h8;
        seq(1, 0, 0, 1, 32'h12, 32'h3020_0073, 0, 32'h10, 32'd2, 32'h3020_0073, 32'h1880, 32'h200);
        bus.ex_valid = 0; bus.illegal_instr = 1; bus.env_call = 1; bus.break_point = 1; bus.mret_instr = 1;
        repeat (5) @(posedge clk);
        #1;
        clear_in();
        base = cyc;
        bus.ex_valid = 1; bus.env_call = 1; bus.ex_pc = 32'h300;
        exp_stall[base] = 1; exp_stall[base + 1] = 1; exp_flush[base] = 1;
        push(base + 1, 0, 12'h341, 32'h300);
        @(posedge clk); #1;
        clear_in();
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("async_rst_csr_we", {31'd0, bus.csr_we}, 0);
        chk("async_rst_waddr", {20'd0, bus.csr_waddr}, 0);
        chk("async_rst_wdata", bus.csr_wdata, 0);
        chk("async_rst_stall", {31'd0, bus.stall}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (8) @(posedge clk);
        #1;
        seq(0, 1, 0, 0, 32'h100, 32'h73, 0, 32'h100, 32'd11, 32'h0, 32'h1880, 32'h200);
        seq(0, 1, 0, 0, 32'h208, 32'h73, 0, 32'h208, 32'd11, 32'h0, 32'h1880, 32'h200);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Multi-cycle trap/return sequencer, sitting beside the EX stage.
- Consumes the decoder exception flags (illegal_instr, env_call, break_point, mret_instr) for the instruction in EX.
- Sequences the single shared CSR read/write port to perform M-mode trap entry or MRET.
- Stalls and flushes the pipeline, then issues one PC redirect.

Parameters:
- MSTATUS_ADDR, 12'h300, mstatus CSR address
- MTVEC_ADDR, 12'h305, mtvec CSR address
- MEPC_ADDR, 12'h341, mepc CSR address
- MCAUSE_ADDR, 12'h342, mcause CSR address
- MTVAL_ADDR, 12'h343, mtval CSR address

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX-stage instruction valid
- ex_pc  in  32  PC of EX instruction
- ex_instr  in  32  raw EX instruction bits
- illegal_instr  in  1  decoder flag
- env_call  in  1  decoder flag (ECALL)
- break_point  in  1  decoder flag (EBREAK)
- mret_instr  in  1  decoder flag (MRET)
- csr_raddr  out  12  CSR read address
- csr_rdata  in  32  CSR read data, combinational from csr_raddr, same cycle
- csr_we  out  1  CSR write enable, committed at rising clk
- csr_waddr  out  12  CSR write address
- csr_wdata  out  32  CSR write data
- stall  out  1  hold IF/ID/EX
- flush  out  1  kill younger (IF/ID) instructions
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (rst_n low, any time including mid-sequence):
  - state=IDLE; all latched regs 0.
  - stall, flush, redirect_valid, csr_we = 0; csr_raddr, csr_waddr, csr_wdata, redirect_pc = 0.
  - No partial sequence resumes after reset release.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_TVEC, M_STATUS, M_EPC, REDIRECT.
- IDLE accept: trap = ex_valid & (illegal_instr|env_call|break_point); ret = ex_valid & mret_instr & ~trap.
  - Priority when multiple flags are set: illegal > ecall > ebreak > mret.
  - In the accept cycle: stall=1, flush=1 (combinational).
  - Latch pc_q = ex_pc.
  - Latch cause_q: illegal=2, ebreak=3, ecall=11 (bit31=0).
  - Latch tval_q: illegal=ex_instr, ebreak=ex_pc, ecall=0.
  - Next state: trap -> T_EPC; ret -> M_STATUS.
- Flags with ex_valid=0 are ignored. Flags arriving in any non-IDLE state are ignored.
- Trap entry (one CSR write per state):
  - T_EPC: write MEPC = {pc_q[31:2],2'b00}.
  - T_CAUSE: write MCAUSE = cause_q.
  - T_TVAL: write MTVAL = tval_q.
  - T_STATUS: raddr=MSTATUS; write rdata with bit7(MPIE)=rdata[3], bit3(MIE)=0, bits12:11(MPP)=2'b11; other bits unchanged.
  - T_TVEC: raddr=MTVEC; target_q = {rdata[31:2],2'b00}. Direct mode only; mode bits are ignored. No write.
- MRET:
  - M_STATUS: raddr=MSTATUS; write rdata with bit3=rdata[7], bit7=1, bits12:11=2'b11.
  - M_EPC: raddr=MEPC; target_q = {rdata[31:2],2'b00}.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target_q for exactly one cycle; flush=1.
  - stall=0 in this cycle, so fetch restarts.
  - Next state IDLE.
- stall = 1 in accept cycle and every state except IDLE and REDIRECT.
- Latency, with accept at cycle 0:
  - Trap: redirect_valid in cycle 6, 5 CSR-port cycles; csr_we high in cycles 1-4.
  - MRET: redirect_valid in cycle 3; csr_we high in cycle 1 only.
- Outside writing states, csr_we=0 and csr_waddr/csr_wdata=0. Outside reading states, csr_raddr=0.
- A new request is acceptable in the cycle after REDIRECT (back-to-back traps supported).

Test Plan:
- ECALL: ex_pc=0x0000_0100, mstatus=0x0000_0008, mtvec=0x0000_0201 -> writes mepc=0x100, mcause=11, mtval=0, mstatus=0x0000_1880; redirect_valid in cycle 6 with redirect_pc=0x200; stall high cycles 0-5.
- Illegal: ex_instr=0xFFFF_FFFF, ex_pc=0x44 -> mcause=2, mtval=0xFFFF_FFFF, mepc=0x44.
- EBREAK at ex_pc=0x80 -> mcause=3, mtval=0x80.
- MRET: mstatus=0x0000_1880, mepc=0x104 -> mstatus write=0x0000_1888; redirect_pc=0x104 in cycle 3; exactly one csr_we pulse.
- Simultaneous illegal_instr+mret_instr -> trap path taken (mcause=2). Flags with ex_valid=0 -> no stall, no CSR activity.
- rst_n low during T_CAUSE -> outputs 0 immediately (async); after release, no further csr_we or redirect until a new request. Back-to-back: ECALL accepted the cycle after REDIRECT -> full second sequence.
